// File: rtl/adder_tree_pkg.sv
// Shared sizing helpers for the binary adder tree: word counts, widths and
// bit offsets of each layer inside the flattened inter-layer bus.
package adder_tree_pkg;

   function automatic int unsigned layer_words(input int unsigned n, input int unsigned s);
      int unsigned m;
      m = n;
      for (int unsigned i = 0; i < s; i++) begin
         m = (m + 1) / 2;
      end
      return m;
   endfunction

   function automatic int unsigned layer_width(input int unsigned w, input int unsigned s);
      return w + s;
   endfunction

   // Layers are packed back to back, layer 0 (the raw inputs) at the LSB end.
   function automatic int unsigned layer_offset(input int unsigned n, input int unsigned w,
                                                input int unsigned s);
      int unsigned off;
      off = 0;
      for (int unsigned i = 0; i < s; i++) begin
         off = off + layer_words(n, i) * layer_width(w, i);
      end
      return off;
   endfunction

endpackage

// File: rtl/adder_tree_stage.sv
// One adder-tree layer: pairwise sums of adjacent words, odd last word passed
// through widened by one bit, optionally registered with an async-reset bank.
module adder_tree_stage
   import adder_tree_pkg::*;
#(
   parameter int unsigned IN_W  = 5,
   parameter int unsigned IN_N  = 7,
   parameter bit          REG   = 1'b0,
   localparam int unsigned OUT_N = layer_words(IN_N, 1),
   localparam int unsigned OUT_W = layer_width(IN_W, 1)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [IN_N*IN_W-1:0]   data_i,
   output logic [OUT_N*OUT_W-1:0] data_o
);

   logic [OUT_N*OUT_W-1:0] sum_d;
   logic [OUT_N*OUT_W-1:0] sum_q;

   for (genvar k = 0; k < OUT_N; k++) begin : g_word
      if (2*k + 1 < IN_N) begin : g_add
         assign sum_d[k*OUT_W +: OUT_W] = {1'b0, data_i[2*k*IN_W +: IN_W]}
                                        + {1'b0, data_i[(2*k+1)*IN_W +: IN_W]};
      end else begin : g_pass
         assign sum_d[k*OUT_W +: OUT_W] = {1'b0, data_i[2*k*IN_W +: IN_W]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q <= '0;
      end else begin
         sum_q <= sum_d;
      end
   end

   // Unregistered layers leave sum_q unloaded, so synthesis drops the bank.
   assign data_o = REG ? sum_q : sum_d;

endmodule

// File: rtl/adder_tree_bin.sv
// Parameterised binary adder tree summing DATA_N unsigned words, with an
// optional pipeline register after each layer selected by FF_P.
module adder_tree_bin
   import adder_tree_pkg::*;
#(
   parameter int unsigned               DATA_W   = 5,
   parameter int unsigned               DATA_N   = 7,
   parameter logic [$clog2(DATA_N)-1:0] FF_P     = '0,
   localparam int unsigned              STAGES_N = $clog2(DATA_N),
   localparam int unsigned              O_DATA_W = DATA_W + STAGES_N
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [0:DATA_N-1][DATA_W-1:0]  i_data,
   output logic [O_DATA_W-1:0]            o_data
);

   localparam int unsigned BUS_W = layer_offset(DATA_N, DATA_W, STAGES_N + 1);

   // Every layer's words live in one flat bus so each stage can size its own slice.
   logic [BUS_W-1:0] tree;

   for (genvar k = 0; k < DATA_N; k++) begin : g_in
      assign tree[k*DATA_W +: DATA_W] = i_data[k];
   end

   for (genvar s = 1; s <= STAGES_N; s++) begin : g_stage
      adder_tree_stage #(
         .IN_W (layer_width(DATA_W, s - 1)),
         .IN_N (layer_words(DATA_N, s - 1)),
         .REG  (FF_P[s-1])
      ) u_stage (
         .clk    (clk),
         .rst_n  (rst_n),
         .data_i (tree[layer_offset(DATA_N, DATA_W, s - 1) +:
                       layer_words(DATA_N, s - 1) * layer_width(DATA_W, s - 1)]),
         .data_o (tree[layer_offset(DATA_N, DATA_W, s) +:
                       layer_words(DATA_N, s) * layer_width(DATA_W, s)])
      );
   end

   assign o_data = tree[layer_offset(DATA_N, DATA_W, STAGES_N) +: O_DATA_W];

endmodule

// File: tb/tb_adder_tree_bin.sv
// Bench for adder_tree_bin: all eight FF_P variants of the 7-input tree plus an
// 8-input tree, checked against a latency-aligned scoreboard of reference sums.
module tb_adder_tree_bin;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [0:6][4:0]     din7;
   logic [0:7][4:0]     din8;
   logic [7:0]          dout7 [8];
   logic [7:0]          dout8;

   int unsigned sb [9][$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int unsigned last_s7  = 0;

   typedef struct {
      logic [4:0]  w [8];
      int unsigned exp7;
      int unsigned exp8;
   } vec_t;

   vec_t tbl [8];

   always #5 clk = ~clk;

   for (genvar f = 0; f < 8; f++) begin : g_dut
      adder_tree_bin #(
         .DATA_W (5),
         .DATA_N (7),
         .FF_P   (3'(f))
      ) u_dut (
         .clk    (clk),
         .rst_n  (rst_n),
         .i_data (din7),
         .o_data (dout7[f])
      );
   end

   adder_tree_bin #(
      .DATA_W (5),
      .DATA_N (8),
      .FF_P   (3'b101)
   ) u_dut8 (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_data (din8),
      .o_data (dout8)
   );

   function automatic int unsigned lat(input int unsigned idx);
      return (idx < 8) ? $countones(idx) : 2;
   endfunction

   task automatic check(input string name, input logic [7:0] got, input int unsigned exp);
      n_checks++;
      if (got !== 8'(exp)) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   // Registered pipelines restart from all-zero contents, i.e. a sum of 0.
   task automatic sb_flush();
      for (int i = 0; i < 9; i++) begin
         sb[i].delete();
         for (int unsigned j = 0; j < lat(i); j++) sb[i].push_back(0);
      end
   endtask

   task automatic drive_check(input logic [4:0] w [8], input int unsigned e7,
                              input int unsigned e8);
      int unsigned exp;
      for (int k = 0; k < 7; k++) din7[k] = w[k];
      for (int k = 0; k < 8; k++) din8[k] = w[k];
      last_s7 = e7;
      for (int i = 0; i < 8; i++) sb[i].push_back(e7);
      sb[8].push_back(e8);
      #1;
      for (int i = 0; i < 8; i++) begin
         exp = sb[i].pop_front();
         check($sformatf("ffp%0d", i), dout7[i], exp);
      end
      exp = sb[8].pop_front();
      check("n8_ffp5", dout8, exp);
   endtask

   task automatic step(input logic [4:0] w [8], input int unsigned e7, input int unsigned e8);
      @(negedge clk);
      drive_check(w, e7, e8);
   endtask

   task automatic rand_step();
      logic [4:0]  w [8];
      int unsigned s7, s8;
      s7 = 0;
      for (int k = 0; k < 8; k++) begin
         w[k] = 5'($urandom_range(0, 31));
         if (k < 7) s7 += w[k];
      end
      s8 = s7 + w[7];
      step(w, s7, s8);
   endtask

   initial begin
      logic [4:0] z [8];
      for (int k = 0; k < 8; k++) z[k] = '0;

      for (int k = 0; k < 8; k++) begin
         tbl[0].w[k] = 5'd31;
         tbl[1].w[k] = 5'(k + 1);
         tbl[2].w[k] = '0;
         tbl[3].w[k] = (k == 6) ? 5'd31 : 5'd0;
         tbl[4].w[k] = (k == 0) ? 5'd31 : 5'd0;
         tbl[5].w[k] = (k % 2 == 0) ? 5'd31 : 5'd0;
         tbl[6].w[k] = (k == 7) ? 5'd31 : 5'd0;
         tbl[7].w[k] = 5'd31;
      end
      tbl[0].exp7 = 217; tbl[0].exp8 = 248;
      tbl[1].exp7 = 28;  tbl[1].exp8 = 36;
      tbl[2].exp7 = 0;   tbl[2].exp8 = 0;
      tbl[3].exp7 = 31;  tbl[3].exp8 = 31;
      tbl[4].exp7 = 31;  tbl[4].exp8 = 31;
      tbl[5].exp7 = 124; tbl[5].exp8 = 124;
      tbl[6].exp7 = 0;   tbl[6].exp8 = 31;
      tbl[7].exp7 = 217; tbl[7].exp8 = 248;

      rst_n = 1'b0;
      for (int k = 0; k < 7; k++) din7[k] = 5'd31;
      for (int k = 0; k < 8; k++) din8[k] = 5'd31;
      repeat (2) @(posedge clk);
      #2;
      check("comb_in_reset", dout7[0], 217);
      for (int i = 1; i < 8; i++) check($sformatf("reset_ffp%0d", i), dout7[i], 0);
      check("reset_n8", dout8, 0);

      @(negedge clk);
      rst_n = 1'b1;
      sb_flush();
      drive_check(z, 0, 0);

      // Table vectors, each held for four cycles so every latency settles.
      for (int t = 0; t < 8; t++) begin
         for (int r = 0; r < 4; r++) step(tbl[t].w, tbl[t].exp7, tbl[t].exp8);
      end

      // Latency-3 path: zeros, then {1..7}; 0 for three cycles, then 28.
      for (int r = 0; r < 3; r++) step(z, 0, 0);
      step(tbl[1].w, 28, 36);
      for (int r = 0; r < 3; r++) step(tbl[1].w, 28, 36);

      for (int r = 0; r < 100; r++) rand_step();

      // Mid-stream reset: registered variants drop to 0 immediately.
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_comb", dout7[0], last_s7);
      for (int i = 1; i < 8; i++) check($sformatf("mid_rst_ffp%0d", i), dout7[i], 0);
      check("mid_rst_n8", dout8, 0);
      @(posedge clk);
      #2;
      for (int i = 1; i < 8; i++) check($sformatf("held_rst_ffp%0d", i), dout7[i], 0);

      @(negedge clk);
      rst_n = 1'b1;
      sb_flush();
      drive_check(tbl[0].w, 217, 248);
      for (int r = 0; r < 150; r++) rand_step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
